aes_block_deserializer: RTL and testbench

- Sits directly downstream of the combinational AES-128 decrypt core in the image path. It consumes 128-bit recovered-plaintext blocks and emits them as an 8-bit grayscale pixel stream, one pixel per cycle.
- Uses valid/ready handshakes on both sides and tracks the pixel count within a frame. It flags the final pixel and discards padding bytes in the last block of a frame.
- Registers the decrypt output, which breaks the long combinational decrypt path from the pixel sink.

---
 rtl/aes_block_deserializer_pkg.sv | 14 +
 rtl/aes_block_deserializer_byte_select.sv | 19 +
 rtl/aes_block_deserializer.sv | 77 +++++++
 tb/tb_aes_block_deserializer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/aes_block_deserializer_pkg.sv
// Shared image-path constants: block/pixel geometry, counter width and the
// deserializer state encoding.
package aes_block_deserializer_pkg;

    localparam int BLK_W         = 128;
    localparam int PIX_W         = 8;
    localparam int BYTES_PER_BLK = 16;
    localparam int IDX_W         = 4;
    localparam int CNT_W         = 24;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

endpackage

// File: rtl/aes_block_deserializer_byte_select.sv
// Picks one byte out of a 128-bit plaintext block; MSB_FIRST chooses whether
// index 0 maps to bits [127:120] or bits [7:0].
module aes_byte_select
    import aes_block_deserializer_pkg::*;
#(
    parameter int MSB_FIRST = 1
)
(
    input  logic [BLK_W-1:0] blk,
    input  logic [IDX_W-1:0] idx,
    output logic [PIX_W-1:0] pix
);

    logic [IDX_W-1:0] pos;

    assign pos = (MSB_FIRST != 0) ? (IDX_W'(BYTES_PER_BLK - 1) - idx) : idx;
    assign pix = blk[{pos, 3'b000} +: PIX_W];

endmodule

// File: rtl/aes_block_deserializer.sv
// Turns 128-bit decrypted blocks into a one-byte-per-cycle pixel stream with
// frame tracking, last-pixel flag and padding discard.
module aes_block_deserializer
    import aes_block_deserializer_pkg::*;
#(
    parameter int IMG_PIXELS = 65536,
    parameter int MSB_FIRST  = 1
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [BLK_W-1:0]   blk_data,
    input  logic               blk_valid,
    output logic               blk_ready,
    output logic [PIX_W-1:0]   pix_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               pix_last,
    output logic               frame_done,
    output logic [CNT_W-1:0]   pix_count
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IMG_PIXELS - 1);

    logic [0:0]       state;
    logic [IDX_W-1:0] byte_idx;
    logic [BLK_W-1:0] hold;
    logic             armed;
    logic             pix_hs;
    logic             blk_hs;
    logic             blk_end;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // blk_ready is a function of state and pix_ready only, never blk_valid.
    assign pix_valid = (state == ST_DRAIN);
    assign pix_last  = pix_valid && (pix_count == LAST_CNT);
    assign pix_hs    = pix_valid && pix_ready;
    assign blk_end   = pix_hs && ((byte_idx == IDX_W'(BYTES_PER_BLK - 1)) || pix_last);
    assign blk_ready = armed && ((state == ST_EMPTY) || blk_end);
    assign blk_hs    = blk_valid && blk_ready;

    aes_byte_select #(.MSB_FIRST(MSB_FIRST)) u_byte_select (
        .blk (hold),
        .idx (byte_idx),
        .pix (pix_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_EMPTY;
            byte_idx   <= '0;
            hold       <= '0;
            pix_count  <= '0;
            frame_done <= 1'b0;
            armed      <= 1'b0;
        end else begin
            armed      <= 1'b1;
            frame_done <= pix_hs && pix_last;
            if (pix_hs) begin
                pix_count <= pix_last ? '0 : pix_count + CNT_W'(1);
            end
            // A block can only be taken when the current one is empty or about
            // to be exhausted, so loading always restarts at byte 0.
            if (blk_hs) begin
                hold     <= blk_data;
                byte_idx <= '0;
                state    <= ST_DRAIN;
            end else if (blk_end) begin
                byte_idx <= '0;
                state    <= ST_EMPTY;
            end else if (pix_hs) begin
                byte_idx <= byte_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_aes_block_deserializer.sv
// Two lockstep instances (MSB-first and LSB-first, 20-pixel frames) checked
// every cycle against a queue-based model of the pixel stream.
module tb_aes_block_deserializer;

    localparam int IMG = 20;
    localparam logic [127:0] BLK_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] BLK_B = 128'h0123456789abcdef0011223344556677;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] blk_data = '0;
    logic         blk_valid = 1'b0;
    logic         pix_ready = 1'b0;

    logic         blk_ready_m, pix_valid_m, pix_last_m, frame_done_m;
    logic [7:0]   pix_data_m;
    logic [23:0]  pix_count_m;
    logic         blk_ready_l, pix_valid_l, pix_last_l, frame_done_l;
    logic [7:0]   pix_data_l;
    logic [23:0]  pix_count_l;

    // Expected stream entries: {last, msb_first_byte, lsb_first_byte}
    logic [16:0]  exp_q[$];
    int           sched;
    int           cnt_exp;
    logic         fd_exp;
    logic         armed;
    int           n_vec;
    int           n_err;

    always #5 clk = ~clk;

    aes_block_deserializer #(.IMG_PIXELS(IMG), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .blk_data(blk_data), .blk_valid(blk_valid),
        .blk_ready(blk_ready_m), .pix_data(pix_data_m), .pix_valid(pix_valid_m),
        .pix_ready(pix_ready), .pix_last(pix_last_m), .frame_done(frame_done_m),
        .pix_count(pix_count_m)
    );

    aes_block_deserializer #(.IMG_PIXELS(IMG), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .blk_data(blk_data), .blk_valid(blk_valid),
        .blk_ready(blk_ready_l), .pix_data(pix_data_l), .pix_valid(pix_valid_l),
        .pix_ready(pix_ready), .pix_last(pix_last_l), .frame_done(frame_done_l),
        .pix_count(pix_count_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        sched   = 0;
        cnt_exp = 0;
        fd_exp  = 1'b0;
        armed   = 1'b0;
    endtask

    // A block contributes at most the pixels left in the frame; the rest is padding.
    task automatic push_block(input logic [127:0] bd);
        int n;
        logic lst;
        n = (IMG - sched < 16) ? IMG - sched : 16;
        for (int i = 0; i < n; i++) begin
            lst = (i == n - 1) && (sched + n == IMG);
            exp_q.push_back({lst, bd[127 - 8*i -: 8], bd[8*i +: 8]});
        end
        sched = (sched + n == IMG) ? 0 : sched + n;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_blk_ready_m"}, 32'(blk_ready_m), 0);
        check({tag, "_blk_ready_l"}, 32'(blk_ready_l), 0);
        check({tag, "_pix_valid_m"}, 32'(pix_valid_m), 0);
        check({tag, "_pix_valid_l"}, 32'(pix_valid_l), 0);
        check({tag, "_pix_last_m"}, 32'(pix_last_m), 0);
        check({tag, "_frame_done_m"}, 32'(frame_done_m), 0);
        check({tag, "_pix_count_m"}, 32'(pix_count_m), 0);
        check({tag, "_pix_count_l"}, 32'(pix_count_l), 0);
        check({tag, "_pix_data_m"}, 32'(pix_data_m), 0);
        check({tag, "_pix_data_l"}, 32'(pix_data_l), 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_before_edge", 32'(blk_ready_m), 0);
        @(posedge clk);
        armed = 1'b1;
    endtask

    task automatic step(input logic bv, input logic [127:0] bd, input logic pr);
        logic        exp_valid, exp_ready, pix_hs, blk_hs;
        logic [16:0] head;
        @(negedge clk);
        blk_valid = bv;
        blk_data  = bv ? bd : {4{$urandom()}};
        pix_ready = pr;
        #1;
        exp_valid = (exp_q.size() != 0);
        head      = exp_valid ? exp_q[0] : 17'h0;
        exp_ready = armed && (!exp_valid || (pr && exp_q.size() == 1));
        check("blk_ready_m", 32'(blk_ready_m), 32'(exp_ready));
        check("blk_ready_l", 32'(blk_ready_l), 32'(exp_ready));
        check("pix_valid_m", 32'(pix_valid_m), 32'(exp_valid));
        check("pix_valid_l", 32'(pix_valid_l), 32'(exp_valid));
        check("pix_last_m", 32'(pix_last_m), 32'(exp_valid && head[16]));
        check("pix_last_l", 32'(pix_last_l), 32'(exp_valid && head[16]));
        check("frame_done_m", 32'(frame_done_m), 32'(fd_exp));
        check("frame_done_l", 32'(frame_done_l), 32'(fd_exp));
        check("pix_count_m", 32'(pix_count_m), 32'(cnt_exp));
        check("pix_count_l", 32'(pix_count_l), 32'(cnt_exp));
        if (exp_valid) begin
            check("pix_data_m", 32'(pix_data_m), 32'(head[15:8]));
            check("pix_data_l", 32'(pix_data_l), 32'(head[7:0]));
        end
        pix_hs = exp_valid && pr;
        blk_hs = bv && exp_ready;
        @(posedge clk);
        fd_exp = pix_hs && head[16];
        if (pix_hs) begin
            void'(exp_q.pop_front());
            cnt_exp = head[16] ? 0 : cnt_exp + 1;
        end
        if (blk_hs) push_block(bd);
        armed = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_clear();

        // Reset values while held in reset
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        release_reset();

        // Single block, MSB and LSB ordering, then idle in EMPTY
        step(1'b1, BLK_A, 1'b1);
        for (int i = 0; i < 18; i++) step(1'b0, '0, 1'b1);

        // Frame end with padding: 4 pixels left in the 20-pixel frame
        step(1'b1, BLK_B, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
        check("count_after_frame", 32'(pix_count_m), 0);
        step(1'b1, BLK_A, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b0, '0, 1'b1);

        // Back-to-back blocks, no gaps
        for (int i = 0; i < 48; i++) step(1'b1, {4{$urandom()}}, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);

        // Backpressure pattern 1,0,0,1,...
        for (int i = 0; i < 90; i++) step(1'b1, {4{$urandom()}}, (i % 3) == 0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);

        // Random traffic
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 3) != 0, {4{$urandom()}}, $urandom_range(0, 3) != 0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);

        // Asynchronous reset mid-block, after five pixels
        step(1'b1, BLK_A, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("async");
        model_clear();
        repeat (2) @(negedge clk);
        release_reset();
        step(1'b1, BLK_A, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
